// File: rtl/fog_demod_pkg.sv
// Shared types and constants for the FOG square-wave demodulator.
package fog_demod_pkg;

  // WAIT_FIRST holds until the first rising phase edge so that the first
  // reported period is never a truncated one.
  typedef enum logic {
    WAIT_FIRST = 1'b0,
    RUN        = 1'b1
  } state_t;

  localparam logic ST_HIGH = 1'b1;
  localparam logic ST_LOW  = 1'b0;
  localparam int   SKIP_W  = 16;

endpackage

// File: rtl/fog_sat_add.sv
// Signed add/subtract of width W with optional clamping.
// Build macro FOG_DEMOD_SAT_EN: when defined, results clamp to the signed
// range of W bits and ovf reports the clamp; otherwise the result wraps
// modulo 2^W and ovf is constant 0.
module fog_sat_add #(
  parameter int W = 32
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                sub,
  output logic signed [W-1:0] y,
  output logic                ovf
);

`ifdef FOG_DEMOD_SAT_EN
  logic [W:0] sum_ext;

  // One extra bit exposes overflow as a mismatch of the top two bits
  always_comb begin
    sum_ext = sub ? ({a[W-1], a} - {b[W-1], b}) : ({a[W-1], a} + {b[W-1], b});
    ovf     = sum_ext[W] ^ sum_ext[W-1];
    if (ovf) begin
      y = sum_ext[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      y = sum_ext[W-1:0];
    end
  end
`else
  assign y   = sub ? (a - b) : (a + b);
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/fog_demod_acc.sv
// Synchronous square-wave demodulator: sums ADC samples per HIGH/LOW
// half-period (after a settle skip) and reports HIGH-LOW once per period.
// Build macro FOG_DEMOD_SAT_EN selects clamping arithmetic and a live o_ovf;
// without it all sums wrap and o_ovf stays 0.
module fog_demod_acc
  import fog_demod_pkg::*;
#(
  parameter int ADC_BIT = 14,
  parameter int ACC_BIT = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_status,
  input  logic signed [ADC_BIT-1:0] i_adc_data,
  input  logic [SKIP_W-1:0]         i_skip_cnt,
  input  logic                      i_polarity,
  output logic signed [ACC_BIT-1:0] o_err,
  output logic                      o_err_vld,
  output logic                      o_ovf
);

  logic                      status_q;
  logic                      status_qq;
  logic signed [ADC_BIT-1:0] adc_q;

  state_t                    state;
  logic [SKIP_W-1:0]         skip_cnt;
  logic signed [ACC_BIT-1:0] acc_h;
  logic signed [ACC_BIT-1:0] acc_l;
  logic                      ovf_acc;

  logic                      ph_edge;
  logic                      rise;
  logic                      fall;
  logic                      take;
  logic signed [ACC_BIT-1:0] sample_ext;
  logic signed [ACC_BIT-1:0] sum_h;
  logic signed [ACC_BIT-1:0] sum_l;
  logic signed [ACC_BIT-1:0] diff;
  logic signed [ACC_BIT-1:0] diff_a;
  logic signed [ACC_BIT-1:0] diff_b;
  logic                      ovf_h;
  logic                      ovf_l;
  logic                      ovf_d;

  // Align phase flag and sample: adc_q belongs to the phase in status_q
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      status_q  <= ST_LOW;
      status_qq <= ST_LOW;
      adc_q     <= '0;
    end else begin
      status_q  <= i_status;
      status_qq <= status_q;
      adc_q     <= i_adc_data;
    end
  end

  assign ph_edge    = status_q != status_qq;
  assign rise       = (status_q == ST_HIGH) && (status_qq == ST_LOW);
  assign fall       = (status_q == ST_LOW) && (status_qq == ST_HIGH);
  // On an edge the fresh skip value decides whether the edge sample counts
  assign take       = ph_edge ? (i_skip_cnt == '0) : (skip_cnt == '0);
  assign sample_ext = {{(ACC_BIT-ADC_BIT){adc_q[ADC_BIT-1]}}, adc_q};
  assign diff_a     = i_polarity ? acc_l : acc_h;
  assign diff_b     = i_polarity ? acc_h : acc_l;

  fog_sat_add #(.W(ACC_BIT)) u_add_h (
    .a(acc_h), .b(sample_ext), .sub(1'b0), .y(sum_h), .ovf(ovf_h)
  );

  fog_sat_add #(.W(ACC_BIT)) u_add_l (
    .a(acc_l), .b(sample_ext), .sub(1'b0), .y(sum_l), .ovf(ovf_l)
  );

  fog_sat_add #(.W(ACC_BIT)) u_diff (
    .a(diff_a), .b(diff_b), .sub(1'b1), .y(diff), .ovf(ovf_d)
  );

  // Phase FSM: skip counting, half-period accumulation and period report
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= WAIT_FIRST;
      skip_cnt  <= '0;
      acc_h     <= '0;
      acc_l     <= '0;
      ovf_acc   <= 1'b0;
      o_err     <= '0;
      o_err_vld <= 1'b0;
      o_ovf     <= 1'b0;
    end else begin
      o_err_vld <= 1'b0;
      case (state)
        WAIT_FIRST: begin
          acc_h   <= '0;
          acc_l   <= '0;
          ovf_acc <= 1'b0;
          if (rise) begin
            skip_cnt <= i_skip_cnt;
            state    <= RUN;
          end
        end
        RUN: begin
          if (ph_edge) begin
            skip_cnt <= take ? '0 : (i_skip_cnt - 1'b1);
          end else if (skip_cnt != '0) begin
            skip_cnt <= skip_cnt - 1'b1;
          end

          if (fall) begin
            o_err     <= diff;
            o_err_vld <= 1'b1;
            o_ovf     <= ovf_acc | ovf_d;
            acc_h     <= '0;
            acc_l     <= take ? sample_ext : '0;
            ovf_acc   <= 1'b0;
          end else if (take) begin
            if (status_q == ST_HIGH) begin
              acc_h   <= sum_h;
              ovf_acc <= ovf_acc | ovf_h;
            end else begin
              acc_l   <= sum_l;
              ovf_acc <= ovf_acc | ovf_l;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fog_demod_acc.sv
// Randomised/directed bench for fog_demod_acc with a half-period level model.
module tb_fog_demod_acc;

  localparam int ADC_BIT = 14;
  localparam int ACC_BIT = 16;
  localparam longint ACC_MAX = 32767;
  localparam longint ACC_MIN = -32768;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      status;
  logic signed [ADC_BIT-1:0] adc;
  logic [15:0]               skip;
  logic                      pol;
  logic signed [ACC_BIT-1:0] err;
  logic                      err_vld;
  logic                      ovf;

  int checks   = 0;
  int failures = 0;

  // Stimulus stream (one entry per clock) and observed/expected events
  bit     s_q[$];
  int     a_q[$];
  int     k_q[$];
  int     o_idx[$];
  longint o_err[$];
  bit     o_ovf[$];
  int     e_idx[$];
  longint e_err[$];
  bit     e_ovf[$];

  fog_demod_acc #(.ADC_BIT(ADC_BIT), .ACC_BIT(ACC_BIT)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_status   (status),
    .i_adc_data (adc),
    .i_skip_cnt (skip),
    .i_polarity (pol),
    .o_err      (err),
    .o_err_vld  (err_vld),
    .o_ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint wrap_acc(input longint v);
    logic signed [ACC_BIT-1:0] t;
    t = v[ACC_BIT-1:0];
    return longint'(t);
  endfunction

  // Arithmetic of the accumulator domain: clamp or wrap depending on build
  function automatic longint acc_op(input longint r, inout bit o);
`ifdef FOG_DEMOD_SAT_EN
    if (r > ACC_MAX) begin o = 1'b1; return ACC_MAX; end
    if (r < ACC_MIN) begin o = 1'b1; return ACC_MIN; end
    return r;
`else
    return wrap_acc(r);
`endif
  endfunction

  // Sum stream samples [from, to) one by one
  function automatic void sum_half(input int from, input int to,
                                   output longint acc, output bit o);
    acc = 0;
    o   = 1'b0;
    for (int i = from; i < to; i++) acc = acc_op(acc + a_q[i], o);
  endfunction

  task automatic push_half(input bit st, input int len, input int sk,
                           input int val, input bit rnd);
    for (int i = 0; i < len; i++) begin
      s_q.push_back(st);
      a_q.push_back(rnd ? int'($urandom_range(0, 16383)) - 8192 : val);
      k_q.push_back(sk);
    end
  endtask

  // Expected reports from the stream: per half-period sums, one report per fall
  task automatic model(input bit p);
    int     starts[$];
    bit     prev = 1'b0;
    bit     running = 1'b0;
    longint hi = 0, lo = 0, d;
    bit     hi_o = 1'b0, lo_o = 1'b0, d_o;
    int     n = s_q.size();
    for (int i = 0; i < n; i++) begin
      if (s_q[i] != prev) starts.push_back(i);
      prev = s_q[i];
    end
    for (int h = 0; h < starts.size(); h++) begin
      int st_i = starts[h];
      int en_i = (h + 1 < starts.size()) ? starts[h+1] : n;
      int sk   = k_q[(st_i + 1 < n) ? st_i + 1 : st_i];
      if (!running) begin
        if (s_q[st_i]) begin
          running = 1'b1;
          sum_half(st_i + 1 + sk, en_i, hi, hi_o);
          lo = 0;
          lo_o = 1'b0;
        end
      end else if (s_q[st_i]) begin
        sum_half(st_i + sk, en_i, hi, hi_o);
      end else begin
        d_o = 1'b0;
        d = acc_op(p ? (lo - hi) : (hi - lo), d_o);
        e_idx.push_back(st_i);
        e_err.push_back(d);
        e_ovf.push_back(hi_o | lo_o | d_o);
        sum_half(st_i + sk, en_i, lo, lo_o);
      end
    end
  endtask

  // Reset, play the stream, then compare every report against the model
  task automatic run(input string name, input bit p, input bit chk_last,
                     input longint last_exp);
    bit last_st;
    int n;
    last_st = s_q[s_q.size()-1];
    push_half(last_st, 3, k_q[k_q.size()-1], 0, 1'b0);
    n = s_q.size();
    @(negedge clk);
    rst_n  = 1'b0;
    status = 1'b0;
    adc    = '0;
    skip   = '0;
    pol    = p;
    #1;
    check({name, "_rst_err"}, longint'(err), 0);
    check({name, "_rst_vld"}, longint'(err_vld), 0);
    check({name, "_rst_ovf"}, longint'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (err_vld) begin
        o_idx.push_back(i - 2);
        o_err.push_back(longint'(err));
        o_ovf.push_back(ovf);
      end
      status = s_q[i];
      adc    = a_q[i][ADC_BIT-1:0];
      skip   = k_q[i][15:0];
    end
    model(p);
    check({name, "_nevt"}, o_idx.size(), e_idx.size());
    for (int i = 0; i < o_idx.size() && i < e_idx.size(); i++) begin
      check({name, "_idx"}, o_idx[i], e_idx[i]);
      check({name, "_err"}, o_err[i], e_err[i]);
      check({name, "_ovf"}, longint'(o_ovf[i]), longint'(e_ovf[i]));
    end
    if (chk_last) begin
      if (o_err.size() == 0) check({name, "_last_present"}, 0, 1);
      else check({name, "_last"}, o_err[o_err.size()-1], last_exp);
    end
    $display("scenario %s pol=%0d cycles=%0d reports=%0d expected=%0d",
             name, p, n, o_idx.size(), e_idx.size());
    s_q.delete(); a_q.delete(); k_q.delete();
    o_idx.delete(); o_err.delete(); o_ovf.delete();
    e_idx.delete(); e_err.delete(); e_ovf.delete();
  endtask

  task automatic periods(input int cnt, input int sk, input int hv, input int lv);
    for (int i = 0; i < cnt; i++) begin
      push_half(1'b1, 8, sk, hv, 1'b0);
      push_half(1'b0, 8, sk, lv, 1'b0);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    status = 1'b0;
    adc    = '0;
    skip   = '0;
    pol    = 1'b0;
    repeat (2) @(negedge clk);

    periods(5, 2, 100, -50);
    run("skip2_pol0", 1'b0, 1'b1, 900);

    periods(5, 2, 100, -50);
    run("skip2_pol1", 1'b1, 1'b1, -900);

    periods(4, 8, 100, -50);
    run("skip8", 1'b0, 1'b1, 0);

    // Leading LOW stretch, then ends mid-HIGH so the next reset lands there
    push_half(1'b0, 5, 0, 77, 1'b0);
    periods(4, 0, 100, -50);
    push_half(1'b1, 5, 0, 100, 1'b0);
    run("skip0", 1'b0, 1'b1, 1200);

    periods(4, 0, 8191, -8192);
`ifdef FOG_DEMOD_SAT_EN
    run("extreme", 1'b0, 1'b1, 32767);
`else
    run("extreme", 1'b0, 1'b1, -8);
`endif

    // Skip changes 2->4 mid-HIGH; takes effect from the following edge
    periods(5, 2, 100, -50);
    for (int i = 20; i < k_q.size(); i++) k_q[i] = 4;
    run("skip_change", 1'b0, 1'b1, 600);

    for (int r = 0; r < 6; r++) begin
      push_half(1'b0, int'($urandom_range(0, 3)), 0, 0, 1'b1);
      for (int h = 0; h < 12; h++) begin
        push_half(h[0] == 1'b0, int'($urandom_range(1, 12)),
                  int'($urandom_range(0, 10)), 0, 1'b1);
      end
      run($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'b0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
